// File: rtl/accel_req_packer.sv
// rtl/accel_req_packer.sv - buffers accelerator requests and emits them as credit-limited AXI-Stream packets.
// Optional ACCEL_REQ_PACKER_OPCODE_BEAT_EN adds the opcode as a third beat; otherwise packets are two beats.
module accel_req_packer #(
  parameter int DATA_WIDTH      = 64,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [DATA_WIDTH-1:0]                  req_op_a,
  input  logic [DATA_WIDTH-1:0]                  req_op_b,
  input  logic [DATA_WIDTH-1:0]                  req_opcode,
  input  logic [1:0]                             req_dest,
  output logic [DATA_WIDTH-1:0]                  m_axis_tdata,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic                                   m_axis_tlast,
  output logic [1:0]                             m_axis_tdest,
  input  logic                                   rsp_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   credit_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

`ifdef ACCEL_REQ_PACKER_OPCODE_BEAT_EN
  localparam bit OPCODE_BEAT = 1'b1;
`else
  localparam bit OPCODE_BEAT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BEAT_A  = 2'd1,
    BEAT_B  = 2'd2,
    BEAT_OP = 2'd3
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem_a    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_b    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_op   [FIFO_DEPTH];
  logic [1:0]            r_mem_dest [FIFO_DEPTH];

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_req_ready;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pkt_b;
  logic [DATA_WIDTH-1:0] r_pkt_op;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic [1:0]            r_tdest;
  logic [OW-1:0]         r_outstanding;
  logic                  r_credit_err;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_beat_hs;
  logic                  w_final_hs;
  logic [CW-1:0]         w_count_next;

  assign w_push     = req_valid && r_req_ready;
  assign w_pop      = (r_state == IDLE) && (r_count != '0) &&
                      (r_outstanding < OW'(MAX_OUTSTANDING));
  assign w_beat_hs  = r_tvalid && m_axis_tready;
  assign w_final_hs = w_beat_hs && r_tlast;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]    <= req_op_a;
      r_mem_b[r_wr_ptr]    <= req_op_b;
      r_mem_op[r_wr_ptr]   <= req_opcode;
      r_mem_dest[r_wr_ptr] <= req_dest;
    end
  end

  // Ready is registered from the next occupancy so it never depends on m_axis_tready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= w_count_next;
      r_req_ready <= (w_count_next < CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= IDLE;
      r_pkt_b  <= '0;
      r_pkt_op <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdest  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_pkt_b  <= r_mem_b[r_rd_ptr];
            r_pkt_op <= r_mem_op[r_rd_ptr];
            r_tdata  <= r_mem_a[r_rd_ptr];
            r_tdest  <= r_mem_dest[r_rd_ptr];
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            r_state  <= BEAT_A;
          end
        end
        BEAT_A: begin
          if (w_beat_hs) begin
            r_tdata <= r_pkt_b;
            r_tlast <= !OPCODE_BEAT;
            r_state <= BEAT_B;
          end
        end
        BEAT_B: begin
          if (w_beat_hs) begin
            if (OPCODE_BEAT) begin
              r_tdata <= r_pkt_op;
              r_tlast <= 1'b1;
              r_state <= BEAT_OP;
            end else begin
              r_tdata  <= '0;
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_tdest  <= '0;
              r_state  <= IDLE;
            end
          end
        end
        BEAT_OP: begin
          if (w_beat_hs) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdest  <= '0;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  // A response arriving alongside an issue nets to zero and is not a credit error.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_outstanding <= '0;
      r_credit_err  <= 1'b0;
    end else begin
      case ({w_final_hs, rsp_done})
        2'b10: r_outstanding <= r_outstanding + OW'(1);
        2'b01: begin
          if (r_outstanding != '0) begin
            r_outstanding <= r_outstanding - OW'(1);
          end else begin
            r_credit_err <= 1'b1;
          end
        end
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tdest  = r_tdest;
  assign outstanding   = r_outstanding;
  assign credit_err    = r_credit_err;

endmodule
